// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that runs one 4-bit CLA slice
// once per nibble, LSB first, with a registered inter-nibble carry.

// 4-bit carry-lookahead slice: all four carries come from p/g terms
module adder_4bit_cla (
    output logic [3:0] sum,
    output logic       Cout,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    // Flat lookahead equations, no ripple inside the slice
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        Cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c;
    end

endmodule

module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic            carry_reg;
    logic [IW-1:0]   idx;

    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      s_nib;
    logic            c_nib;

    // Select the current nibble of each captured operand
    always_comb begin
        a_nib = a_reg[4*idx +: 4];
        b_nib = b_reg[4*idx +: 4];
    end

    adder_4bit_cla u_slice (
        .sum  (s_nib),
        .Cout (c_nib),
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_reg)
    );

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            Cout      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    sum[4*idx +: 4] <= s_nib;
                    carry_reg       <= c_nib;
                    idx             <= idx + IW'(1);
                    if (idx == LAST) begin
                        idx       <= '0;
                        Cout      <= c_nib;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Bench for cla_nibble_serial_adder: WIDTH=16 and WIDTH=4 instances
// checked against a transaction-level model every cycle.

module tb_cla_nibble_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        iv16 = 1'b0, or16 = 1'b0, c16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ir16, ov16, co16, bz16;
    logic [15:0] s16;

    logic        iv4 = 1'b0, or4 = 1'b0, c4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        ir4, ov4, co4, bz4;
    logic [3:0]  s4;

    cla_nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(c16),
        .out_valid(ov16), .out_ready(or16),
        .sum(s16), .Cout(co16), .busy(bz16)
    );

    cla_nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(c4),
        .out_valid(ov4), .out_ready(or4),
        .sum(s4), .Cout(co4), .busy(bz4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Transaction model: cycles left in ADD, done flag, last result
    int          m16_cnt, m4_cnt;
    bit          m16_done, m4_done;
    logic [16:0] m16_res, m16_pend;
    logic [4:0]  m4_res, m4_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m16_cnt = 0; m16_done = 0; m16_res = '0;
        end else if (m16_cnt > 0) begin
            m16_cnt--;
            if (m16_cnt == 0) begin
                m16_done = 1;
                m16_res  = m16_pend;
            end
        end else if (m16_done) begin
            if (or16) m16_done = 0;
        end else if (iv16) begin
            m16_pend = {1'b0, a16} + {1'b0, b16} + {16'd0, c16};
            m16_cnt  = 4;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4_cnt = 0; m4_done = 0; m4_res = '0;
        end else if (m4_cnt > 0) begin
            m4_cnt--;
            if (m4_cnt == 0) begin
                m4_done = 1;
                m4_res  = m4_pend;
            end
        end else if (m4_done) begin
            if (or4) m4_done = 0;
        end else if (iv4) begin
            m4_pend = {1'b0, a4} + {1'b0, b4} + {4'd0, c4};
            m4_cnt  = 1;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("w16_busy", 32'(bz16), 32'(m16_cnt > 0 || m16_done));
            chk("w16_in_ready", 32'(ir16), 32'(!(m16_cnt > 0 || m16_done)));
            chk("w16_out_valid", 32'(ov16), 32'(m16_done));
            if (m16_cnt == 0) begin
                chk("w16_sum", 32'(s16), 32'(m16_res[15:0]));
                chk("w16_cout", 32'(co16), 32'(m16_res[16]));
            end
            chk("w4_busy", 32'(bz4), 32'(m4_cnt > 0 || m4_done));
            chk("w4_in_ready", 32'(ir4), 32'(!(m4_cnt > 0 || m4_done)));
            chk("w4_out_valid", 32'(ov4), 32'(m4_done));
            if (m4_cnt == 0) begin
                chk("w4_sum", 32'(s4), 32'(m4_res[3:0]));
                chk("w4_cout", 32'(co4), 32'(m4_res[4]));
            end
        end
    end

    // One transaction; called at posedge+2. exp = {Cout, sum}
    task automatic op(input bit w4, input logic [15:0] a, b,
                      input logic c, input logic [16:0] exp,
                      input int hold);
        int g;
        int lat;
        logic [16:0] got;
        g = 0;
        while (!(w4 ? ir4 : ir16) && g < 50) begin
            @(posedge clk); #2; g++;
        end
        chk("ready_wait", 32'(w4 ? ir4 : ir16), 32'd1);
        if (w4) begin
            a4 = a[3:0]; b4 = b[3:0]; c4 = c; iv4 = 1'b1;
        end else begin
            a16 = a; b16 = b; c16 = c; iv16 = 1'b1;
        end
        @(posedge clk); #2;
        iv4 = 1'b0; iv16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 0;
        while (!(w4 ? ov4 : ov16) && lat < 20) begin
            @(posedge clk); #2; lat++;
        end
        chk("latency", 32'(lat), w4 ? 32'd1 : 32'd4);
        got = w4 ? {12'd0, co4, s4} : {co16, s16};
        chk("result", 32'(got), w4 ? 32'({exp[4:0]}) : 32'(exp));
        repeat (hold) begin
            if (w4) begin
                iv4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom);
            end else begin
                iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
            end
            @(posedge clk); #2;
            chk("hold_in_ready", 32'(w4 ? ir4 : ir16), 32'd0);
            got = w4 ? {12'd0, co4, s4} : {co16, s16};
            chk("hold_result", 32'(got), w4 ? 32'({exp[4:0]}) : 32'(exp));
        end
        iv4 = 1'b0; iv16 = 1'b0;
        if (w4) or4 = 1'b1; else or16 = 1'b1;
        @(posedge clk); #2;
        or4 = 1'b0; or16 = 1'b0;
        chk("release_in_ready", 32'(w4 ? ir4 : ir16), 32'd1);
        chk("release_out_valid", 32'(w4 ? ov4 : ov16), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", 32'(ir16), 32'd1);
        chk("rst_out_valid", 32'(ov16), 32'd0);
        chk("rst_busy", 32'(bz16), 32'd0);
        chk("rst_sum", 32'(s16), 32'd0);
        chk("rst_cout", 32'(co16), 32'd0);
        chk("rst4_in_ready", 32'(ir4), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        op(0, 16'h1234, 16'h4321, 1'b1, 17'h05556, 0);
        op(0, 16'hFFFF, 16'h0000, 1'b1, 17'h10000, 0);
        op(0, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 0);
        op(0, 16'h00F0, 16'h0010, 1'b0, 17'h00100, 0);
        op(0, 16'hA5A5, 16'h5A5A, 1'b0, 17'h0FFFF, 3);

        // Asynchronous reset in the second ADD cycle
        a16 = 16'h8888; b16 = 16'h8888; c16 = 1'b1; iv16 = 1'b1;
        @(posedge clk); #2;
        iv16 = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(ov16), 32'd0);
        chk("arst_sum", 32'(s16), 32'd0);
        chk("arst_cout", 32'(co16), 32'd0);
        chk("arst_in_ready", 32'(ir16), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        op(0, 16'h0001, 16'h0001, 1'b0, 17'h00002, 0);

        op(1, 16'd1, 16'd2, 1'b1, 17'd4, 0);
        op(1, 16'd2, 16'd5, 1'b0, 17'd7, 0);
        op(1, 16'd5, 16'd6, 1'b1, 17'd12, 0);
        op(1, 16'd6, 16'd8, 1'b0, 17'd14, 0);
        op(1, 16'd2, 16'd9, 1'b1, 17'd12, 1);
        op(1, 16'd15, 16'd1, 1'b0, 17'h10, 0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            logic        rc;
            logic [16:0] e;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (i % 2 == 0) begin
                e = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
                op(0, ra, rb, rc, e, int'($urandom_range(0, 2)));
            end else begin
                e = {13'd0, ra[3:0]} + {13'd0, rb[3:0]} + {16'd0, rc};
                op(1, ra, rb, rc, e, int'($urandom_range(0, 2)));
            end
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
